// File: rtl/scrub_buffer_arbiter.sv
// scrub_buffer_arbiter: round-robin owner of one shared scratch buffer.
// Every ownership change zero-scrubs the whole buffer before the next grant,
// and reads by anyone other than the current owner return zero.
module scrub_buffer_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_HOLD = 64,
  localparam int unsigned AW  = $clog2(DEPTH),
  localparam int unsigned IDW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  input  logic [IDW-1:0]     op_id,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               scrub_busy,
  output logic               scrub_done,
  output logic               revoked
);

  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NUM_REQ - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] SCRUB = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               scrub_busy_q, scrub_busy_d;
  logic               scrub_done_q, scrub_done_d;
  logic               revoked_q, revoked_d;

  logic               found;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     win_next;
  logic               hold_exp;

  // Round-robin pick: first set request scanning upward from rr pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[IDW'((32'(rr_q) + i) % NUM_REQ)]) begin
        found = 1'b1;
        win   = IDW'((32'(rr_q) + i) % NUM_REQ);
      end
    end
    win_next = (win == ID_LAST) ? '0 : win + IDW'(1);
    hold_exp = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  end

  // Next-state, buffer update and read-port logic.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    hold_d       = hold_q;
    ptr_d        = ptr_q;
    mem_d        = mem_q;
    scrub_done_d = 1'b0;
    revoked_d    = 1'b0;
    rd_valid_d   = rd_en;
    rd_data_d    = '0;

    // Old contents are read before any same-cycle write lands.
    if (rd_en && gnt_q[op_id]) begin
      rd_data_d = mem_q[rd_addr];
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = GRANT;
          gnt_d        = '0;
          gnt_d[win]   = 1'b1;
          owner_d      = win;
          rr_d         = win_next;
          hold_d       = '0;
        end
      end
      GRANT: begin
        hold_d = hold_q + HW'(1);
        if (wr_en && gnt_q[op_id]) begin
          mem_d[wr_addr] = wr_data;
        end
        if (!req[owner_q] || hold_exp) begin
          state_d   = SCRUB;
          gnt_d     = '0;
          ptr_d     = '0;
          revoked_d = hold_exp && req[owner_q];
        end
      end
      SCRUB: begin
        mem_d[ptr_q] = '0;
        ptr_d        = ptr_q + AW'(1);
        if (ptr_q == PTR_LAST) begin
          state_d      = IDLE;
          scrub_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    scrub_busy_d = (state_d == SCRUB);
  end

  // State and datapath registers; reset zeroes the whole buffer at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      owner_q      <= '0;
      rr_q         <= '0;
      hold_q       <= '0;
      ptr_q        <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      scrub_busy_q <= 1'b0;
      scrub_done_q <= 1'b0;
      revoked_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      hold_q       <= hold_d;
      ptr_q        <= ptr_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      scrub_busy_q <= scrub_busy_d;
      scrub_done_q <= scrub_done_d;
      revoked_q    <= revoked_d;
      mem_q        <= mem_d;
    end
  end

  assign gnt        = gnt_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign scrub_busy = scrub_busy_q;
  assign scrub_done = scrub_done_q;
  assign revoked    = revoked_q;

endmodule

// File: tb/tb_scrub_buffer_arbiter.sv
// Directed bench for scrub_buffer_arbiter: default instance plus a MAX_HOLD=8 instance.
module tb_scrub_buffer_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [1:0] op_id;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [1:0] rd_addr;

  logic [3:0] gnt, h_gnt;
  logic [7:0] rd_data, h_rd_data;
  logic       rd_valid, h_rd_valid;
  logic       scrub_busy, h_scrub_busy;
  logic       scrub_done, h_scrub_done;
  logic       revoked, h_revoked;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  scrub_buffer_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .op_id(op_id),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .scrub_busy(scrub_busy), .scrub_done(scrub_done), .revoked(revoked)
  );

  scrub_buffer_arbiter #(.MAX_HOLD(8)) dut_h (
    .clk(clk), .rst(rst), .req(req), .gnt(h_gnt), .op_id(op_id),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(h_rd_data), .rd_valid(h_rd_valid),
    .scrub_busy(h_scrub_busy), .scrub_done(h_scrub_done), .revoked(h_revoked)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; op_id = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    req = 4'b1111;
    rd_en = 1'b1;
    tick();
    tick();
    n_total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
    n_total++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) $display("FAIL reset_rd: got v=%b d=%h want v=0 d=00", rd_valid, rd_data); else n_pass++;
    n_total++; if ({scrub_busy, scrub_done, revoked} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {scrub_busy, scrub_done, revoked}); else n_pass++;
    n_total++; if (h_gnt !== 4'b0000) $display("FAIL reset_h_gnt: got %b want 0000", h_gnt); else n_pass++;
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_grant_rw();
    req = 4'b0001;
    tick();
    n_total++; if (gnt !== 4'b0001) $display("FAIL t1_gnt: got %b want 0001", gnt); else n_pass++;
    op_id = 2'd0; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 2'd2;
    tick();
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) $display("FAIL t1_read: got v=%b d=%h want v=1 d=a5", rd_valid, rd_data); else n_pass++;
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    n_total++; if (rd_data !== 8'hA5) $display("FAIL t1_rd_old_on_wr: got %h want a5", rd_data); else n_pass++;
    tick();
    n_total++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) $display("FAIL t1_rd_idle: got v=%b d=%h want v=0 d=00", rd_valid, rd_data); else n_pass++;
    rd_en = 1'b1; rd_addr = 2'd2;
    tick();
    rd_en = 1'b0;
    n_total++; if (rd_data !== 8'h3C) $display("FAIL t1_rd_new: got %h want 3c", rd_data); else n_pass++;
  endtask

  task automatic test_scrub_handover();
    int busy_cnt;
    int done_cnt;
    int grant_at;
    busy_cnt = 0; done_cnt = 0; grant_at = 0;
    req = 4'b0010;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (scrub_busy) busy_cnt++;
      if (scrub_done) done_cnt++;
      if (gnt !== 4'b0000 && grant_at == 0) grant_at = i;
    end
    n_total++; if (busy_cnt != 4) $display("FAIL t2_busy_cycles: got %0d want 4", busy_cnt); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL t2_done_pulses: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (grant_at != 6) $display("FAIL t2_grant_edge: got %0d want 6", grant_at); else n_pass++;
    n_total++; if (gnt !== 4'b0010) $display("FAIL t2_gnt: got %b want 0010", gnt); else n_pass++;
    op_id = 2'd1; rd_en = 1'b1; rd_addr = 2'd2;
    tick();
    rd_en = 1'b0;
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) $display("FAIL t2_scrubbed: got v=%b d=%h want v=1 d=00", rd_valid, rd_data); else n_pass++;
  endtask

  task automatic test_non_owner();
    op_id = 2'd0; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 2'd0;
    tick();
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) $display("FAIL t3_nonowner_rd: got v=%b d=%h want v=1 d=00", rd_valid, rd_data); else n_pass++;
    op_id = 2'd1;
    tick();
    n_total++; if (rd_data !== 8'h00) $display("FAIL t3_write_dropped: got %h want 00", rd_data); else n_pass++;
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 2'd1;
    tick();
    rd_en = 1'b0;
    n_total++; if (rd_data !== 8'h77) $display("FAIL t3_owner_rd: got %h want 77", rd_data); else n_pass++;
    n_total++; if (revoked !== 1'b0 || gnt !== 4'b0010) $display("FAIL t3_still_owner: got rv=%b gnt=%b want rv=0 gnt=0010", revoked, gnt); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] got [5];
    logic [3:0] exp [5];
    logic [3:0] prev;
    int n;
    int dones;
    exp[0] = 4'b0001; exp[1] = 4'b0010; exp[2] = 4'b0100; exp[3] = 4'b1000; exp[4] = 4'b0001;
    for (int k = 0; k < 5; k++) got[k] = '0;
    do_reset();
    prev = '0; n = 0; dones = 0;
    req = 4'b1111;
    for (int c = 0; c < 200 && n < 5; c++) begin
      tick();
      if (h_scrub_done) dones++;
      if (h_gnt !== 4'b0000 && prev === 4'b0000) begin
        got[n] = h_gnt;
        n++;
      end
      prev = h_gnt;
    end
    n_total++; if (n != 5) $display("FAIL t4_grant_count: got %0d want 5 (timeout)", n); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_total++; if (got[k] !== exp[k]) $display("FAIL t4_order[%0d]: got %b want %b", k, got[k], exp[k]); else n_pass++;
    end
    n_total++; if (dones != 4) $display("FAIL t4_scrubs: got %0d want 4", dones); else n_pass++;
  endtask

  task automatic test_max_hold();
    int held;
    do_reset();
    req = 4'b0001;
    tick();
    n_total++; if (h_gnt !== 4'b0001) $display("FAIL t5_gnt: got %b want 0001", h_gnt); else n_pass++;
    held = 1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (h_gnt === 4'b0001) held++;
    end
    n_total++; if (held != 8) $display("FAIL t5_hold_cycles: got %0d want 8", held); else n_pass++;
    tick();
    n_total++; if ({h_gnt, h_revoked, h_scrub_busy} !== 6'b0000_1_1) $display("FAIL t5_revoke: got gnt=%b rv=%b busy=%b want 0000 1 1", h_gnt, h_revoked, h_scrub_busy); else n_pass++;
    tick();
    n_total++; if (h_revoked !== 1'b0) $display("FAIL t5_revoke_pulse: got %b want 0", h_revoked); else n_pass++;
    tick();
    tick();
    tick();
    n_total++; if (h_scrub_done !== 1'b1 || h_gnt !== 4'b0000) $display("FAIL t5_scrub_done: got done=%b gnt=%b want 1 0000", h_scrub_done, h_gnt); else n_pass++;
    tick();
    n_total++; if (h_gnt !== 4'b0001) $display("FAIL t5_regrant: got %b want 0001", h_gnt); else n_pass++;
  endtask

  task automatic test_reset_mid_scrub();
    do_reset();
    req = 4'b0001;
    tick();
    op_id = 2'd0; wr_en = 1'b1; wr_data = 8'h5A;
    for (int a = 0; a < 4; a++) begin
      wr_addr = 2'(a);
      tick();
    end
    wr_en = 1'b0; req = 4'b0000;
    tick();
    n_total++; if (scrub_busy !== 1'b1) $display("FAIL t6_scrub_start: got %b want 1", scrub_busy); else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    n_total++; if ({gnt, scrub_busy, scrub_done} !== 6'b0000_0_0) $display("FAIL t6_reset: got gnt=%b busy=%b done=%b want 0000 0 0", gnt, scrub_busy, scrub_done); else n_pass++;
    rst = 1'b0; req = 4'b0001;
    tick();
    n_total++; if (gnt !== 4'b0001) $display("FAIL t6_idle_grant: got %b want 0001", gnt); else n_pass++;
    rd_en = 1'b1; op_id = 2'd0;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      tick();
      n_total++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) $display("FAIL t6_zero[%0d]: got v=%b d=%h want v=1 d=00", a, rd_valid, rd_data); else n_pass++;
    end
    rd_en = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_grant_rw();
    test_scrub_handover();
    test_non_owner();
    test_round_robin();
    test_max_hold();
    test_reset_mid_scrub();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
